// File: rtl/vga_stream_out.sv
// VGA scan-out engine: pixel stream in (valid/ready + SOP), timing generator, resync FSM, DAC drive.
// Optional macro VGA_TEST_PATTERN_EN adds pattern_sel and an 8-bar colour test pattern.
module vga_stream_out #(
    parameter int COLOR_BITS = 8,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int PIX_DIV    = 2
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic [3*COLOR_BITS-1:0] st_data,
    input  logic                    st_valid,
    input  logic                    st_sop,
    output logic                    st_ready,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                    pattern_sel,
`endif
    output logic [COLOR_BITS-1:0]   vga_vga_red,
    output logic [COLOR_BITS-1:0]   vga_vga_grn,
    output logic [COLOR_BITS-1:0]   vga_vga_blu,
    output logic                    vga_vga_hsync,
    output logic                    vga_vga_vsync,
    output logic                    vga_vga_blank_n,
    output logic                    vga_vga_clk,
    output logic                    frame_start,
    output logic                    underflow_sticky,
    input  logic                    underflow_clr
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int DW      = $clog2(PIX_DIV);
    localparam int CW      = 3 * COLOR_BITS;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(PIX_DIV / 2);

    typedef enum logic {RESYNC, RUN} state_t;

    state_t          state;
    state_t          state_next;
    logic [DW-1:0]   div;
    logic [HW-1:0]   h;
    logic [VW-1:0]   v;
    logic            pix_en;
    logic            active;
    logic            at_origin;
    logic            in_hs;
    logic            in_vs;
    logic            show;
    logic            sticky_set;
    logic            ready;
    logic [CW-1:0]   pix_rgb;

    assign pix_en    = (div == DIV_LAST);
    assign active    = (h < H_ACT) && (v < V_ACT);
    assign at_origin = (h == '0) && (v == '0);
    assign in_hs     = (h >= HS_BEG) && (h < HS_END);
    assign in_vs     = (v >= VS_BEG) && (v < VS_END);
    assign st_ready  = ready;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= RESYNC;
        end else begin
            state <= state_next;
        end
    end

    // Resync FSM: lock only on an SOP beat at (0,0); any starvation or stray SOP drops back out.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        show       = 1'b0;
        sticky_set = 1'b0;
        if (state == RESYNC) begin
            ready = st_sop ? (pix_en && at_origin) : 1'b1;
            if (pix_en && at_origin && st_valid && st_sop) begin
                show       = 1'b1;
                state_next = RUN;
            end
        end else begin
            ready = pix_en && active && !(st_sop && !at_origin);
            if (pix_en && active) begin
                if (!st_valid || (st_sop && !at_origin)) begin
                    sticky_set = 1'b1;
                    state_next = RESYNC;
                end else begin
                    show = 1'b1;
                end
            end
        end
`ifdef VGA_TEST_PATTERN_EN
        if (pattern_sel) begin
            ready      = 1'b1;
            show       = 1'b0;
            sticky_set = 1'b0;
            state_next = RESYNC;
        end
`endif
        if (reset_reset) begin
            ready = 1'b0;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;

    // Bar index h*8/H_ACTIVE found by threshold compare to avoid a divider.
    always_comb begin
        bar = 3'd0;
        for (int b = 1; b < 8; b++) begin
            if (int'(h) * 8 >= b * H_ACTIVE) begin
                bar = 3'(b);
            end
        end
    end
`endif

    always_comb begin
        pix_rgb = '0;
        if (show) begin
            pix_rgb = st_data;
        end
`ifdef VGA_TEST_PATTERN_EN
        if (pattern_sel && active) begin
            pix_rgb = {{COLOR_BITS{bar[2]}}, {COLOR_BITS{bar[1]}}, {COLOR_BITS{bar[0]}}};
        end
`endif
    end

    // Timing counters and registered DAC outputs
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            div              <= '0;
            h                <= '0;
            v                <= '0;
            vga_vga_red      <= '0;
            vga_vga_grn      <= '0;
            vga_vga_blu      <= '0;
            vga_vga_blank_n  <= 1'b0;
            vga_vga_hsync    <= ~HS_POL;
            vga_vga_vsync    <= ~VS_POL;
            vga_vga_clk      <= 1'b0;
            frame_start      <= 1'b0;
            underflow_sticky <= 1'b0;
        end else begin
            div         <= pix_en ? '0 : div + DW'(1);
            vga_vga_clk <= (div >= DIV_HALF);
            frame_start <= pix_en && at_origin;
            if (sticky_set) begin
                underflow_sticky <= 1'b1;
            end else if (underflow_clr) begin
                underflow_sticky <= 1'b0;
            end
            if (pix_en) begin
                if (h == H_LAST) begin
                    h <= '0;
                    v <= (v == V_LAST) ? '0 : v + VW'(1);
                end else begin
                    h <= h + HW'(1);
                end
                vga_vga_blank_n <= active;
                vga_vga_hsync   <= in_hs ? HS_POL : ~HS_POL;
                vga_vga_vsync   <= in_vs ? VS_POL : ~VS_POL;
                {vga_vga_red, vga_vga_grn, vga_vga_blu} <= pix_rgb;
            end
        end
    end

endmodule

// File: tb/tb_vga_stream_out.sv
// Directed bench for vga_stream_out on a 14x7 raster (8x4 active), 4-bit colour, PIX_DIV=2.
// Cycle c counts negedges after the last reset edge; pixel p is shown in cycles 2p+2 and 2p+3.
module tb_vga_stream_out;

    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic [11:0] st_data = '0;
    logic        st_valid = 1'b0;
    logic        st_sop = 1'b0;
    logic        st_ready;
    logic        underflow_clr = 1'b0;
    logic [3:0]  vga_vga_red, vga_vga_grn, vga_vga_blu;
    logic        vga_vga_hsync, vga_vga_vsync, vga_vga_blank_n, vga_vga_clk;
    logic        frame_start, underflow_sticky;
    logic [11:0] rgb;
`ifdef VGA_TEST_PATTERN_EN
    logic        pattern_sel = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    assign rgb = {vga_vga_red, vga_vga_grn, vga_vga_blu};

    always #5 clk_clk = ~clk_clk;

    vga_stream_out #(
        .COLOR_BITS(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIX_DIV(2)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset(reset_reset),
        .st_data(st_data),
        .st_valid(st_valid),
        .st_sop(st_sop),
        .st_ready(st_ready),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .vga_vga_red(vga_vga_red),
        .vga_vga_grn(vga_vga_grn),
        .vga_vga_blu(vga_vga_blu),
        .vga_vga_hsync(vga_vga_hsync),
        .vga_vga_vsync(vga_vga_vsync),
        .vga_vga_blank_n(vga_vga_blank_n),
        .vga_vga_clk(vga_vga_clk),
        .frame_start(frame_start),
        .underflow_sticky(underflow_sticky),
        .underflow_clr(underflow_clr)
    );

    function automatic int pix(input int c);
        return (c < 2) ? -1 : ((c - 2) / 2) % 98;
    endfunction

    function automatic logic e_blank(input int c);
        int p;
        p = pix(c);
        if (p < 0) return 1'b0;
        return (p % 14 < 8) && (p / 14 < 4);
    endfunction

    function automatic logic e_hs(input int c);
        int p;
        p = pix(c);
        if (p < 0) return 1'b1;
        return !((p % 14 == 10) || (p % 14 == 11));
    endfunction

    function automatic logic e_vs(input int c);
        int p;
        p = pix(c);
        if (p < 0) return 1'b1;
        return !(p / 14 == 5);
    endfunction

    function automatic logic e_vclk(input int c);
        return (c > 0) && (c % 2 == 0);
    endfunction

    function automatic logic e_fs(input int c);
        return (c >= 2) && ((c - 2) % 196 == 0);
    endfunction

    function automatic logic [11:0] e_idx(input int c);
        int p;
        p = pix(c);
        if (p < 0) return 12'h000;
        if ((p % 14 < 8) && (p / 14 < 4)) return 12'((p / 14) * 8 + p % 14);
        return 12'h000;
    endfunction

    task automatic do_reset();
        @(negedge clk_clk);
        reset_reset   = 1'b1;
        st_valid      = 1'b0;
        st_sop        = 1'b0;
        st_data       = '0;
        underflow_clr = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
        pattern_sel   = 1'b0;
`endif
        repeat (2) @(negedge clk_clk);
        reset_reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk_clk);
        reset_reset = 1'b1;
        st_valid = 1'b1;
        st_sop = 1'b0;
        st_data = 12'hABC;
        repeat (2) @(negedge clk_clk);
        #1;
        vectors++;
        if (st_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: got %b expected 0", st_ready);
        end
        vectors++;
        if ({rgb, vga_vga_blank_n, vga_vga_hsync, vga_vga_vsync, vga_vga_clk, frame_start, underflow_sticky}
            !== {12'h000, 6'b011000}) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h/%b%b%b%b%b%b expected 000/011000", rgb, vga_vga_blank_n,
                     vga_vga_hsync, vga_vga_vsync, vga_vga_clk, frame_start, underflow_sticky);
        end
        reset_reset = 1'b0;
        #1;
        vectors++;
        if (st_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_ready: got %b expected 1", st_ready);
        end
        st_valid = 1'b0;
    endtask

    task automatic test_idle();
        int blank_cnt = 0;
        int fs_last = -1;
        int fs_cnt = 0;
        do_reset();
        for (int c = 0; c < 396; c++) begin
            vectors++;
            if ({vga_vga_hsync, vga_vga_vsync, vga_vga_blank_n, vga_vga_clk, frame_start}
                !== {e_hs(c), e_vs(c), e_blank(c), e_vclk(c), e_fs(c)}) begin
                miscompares++;
                $display("FAIL idle_timing c=%0d: got %b%b%b%b%b expected %b%b%b%b%b", c, vga_vga_hsync,
                         vga_vga_vsync, vga_vga_blank_n, vga_vga_clk, frame_start,
                         e_hs(c), e_vs(c), e_blank(c), e_vclk(c), e_fs(c));
            end
            vectors++;
            if (rgb !== 12'h000) begin
                miscompares++;
                $display("FAIL idle_rgb c=%0d: got %h expected 000", c, rgb);
            end
            if (c >= 2 && c < 198 && vga_vga_blank_n === 1'b1) blank_cnt++;
            if (frame_start === 1'b1) begin
                if (fs_last >= 0) begin
                    vectors++;
                    if (c - fs_last !== 196) begin
                        miscompares++;
                        $display("FAIL fs_period: got %0d expected 196", c - fs_last);
                    end
                end
                fs_last = c;
                fs_cnt++;
            end
            #1;
            vectors++;
            if (st_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL idle_ready c=%0d: got %b expected 1", c, st_ready);
            end
            @(negedge clk_clk);
        end
        vectors++;
        if (blank_cnt !== 64) begin
            miscompares++;
            $display("FAIL blank_count: got %0d clks expected 64", blank_cnt);
        end
        vectors++;
        if (fs_cnt !== 3) begin
            miscompares++;
            $display("FAIL fs_count: got %0d expected 3", fs_cnt);
        end
    endtask

    task automatic test_stream();
        int idx = 0;
        int beats = 0;
        logic acc_prev = 1'b0;
        logic [11:0] last = '0;
        do_reset();
        for (int c = 0; c < 392; c++) begin
            vectors++;
            if (rgb !== e_idx(c)) begin
                miscompares++;
                $display("FAIL stream_rgb c=%0d: got %h expected %h", c, rgb, e_idx(c));
            end
            if (acc_prev) begin
                vectors++;
                if (rgb !== last) begin
                    miscompares++;
                    $display("FAIL stream_latency c=%0d: got %h expected %h", c, rgb, last);
                end
            end
            vectors++;
            if (underflow_sticky !== 1'b0) begin
                miscompares++;
                $display("FAIL stream_sticky c=%0d: got %b expected 0", c, underflow_sticky);
            end
            st_valid = 1'b1;
            st_sop = (idx == 0);
            st_data = 12'(idx);
            #1;
            acc_prev = st_valid && st_ready;
            if (acc_prev) begin
                last = st_data;
                beats++;
                idx = (idx + 1) % 32;
            end
            @(negedge clk_clk);
        end
        vectors++;
        if (beats !== 64) begin
            miscompares++;
            $display("FAIL stream_beats: got %0d expected 64", beats);
        end
        st_valid = 1'b0;
    endtask

    task automatic test_underflow();
        int idx = 0;
        int relock = -1;
        logic [11:0] exp;
        do_reset();
        for (int c = 0; c < 394; c++) begin
            exp = (c >= 2 && (c - 2) / 196 == 0 && pix(c) >= 17) ? 12'h000 : e_idx(c);
            vectors++;
            if (rgb !== exp) begin
                miscompares++;
                $display("FAIL underflow_rgb c=%0d: got %h expected %h", c, rgb, exp);
            end
            vectors++;
            if (underflow_sticky !== (c >= 36 && c <= 300)) begin
                miscompares++;
                $display("FAIL underflow_sticky c=%0d: got %b expected %b", c, underflow_sticky,
                         (c >= 36 && c <= 300));
            end
            st_valid = (c != 35);
            st_sop = (idx == 0);
            st_data = 12'(idx);
            underflow_clr = (c == 35) || (c == 300);
            #1;
            if (st_valid && st_ready) begin
                if (idx == 0 && c > 35 && relock < 0) relock = c;
                idx = (idx + 1) % 32;
            end
            @(negedge clk_clk);
        end
        underflow_clr = 1'b0;
        st_valid = 1'b0;
        vectors++;
        if (relock !== 197) begin
            miscompares++;
            $display("FAIL underflow_relock: got cycle %0d expected 197", relock);
        end
    endtask

    task automatic test_misplaced_sop();
        int idx = 0;
        int taken = -1;
        logic restarted = 1'b0;
        logic [11:0] exp;
        do_reset();
        for (int c = 0; c < 394; c++) begin
            exp = (c >= 2 && (c - 2) / 196 == 0 && pix(c) >= 5) ? 12'h000 : e_idx(c);
            vectors++;
            if (rgb !== exp) begin
                miscompares++;
                $display("FAIL sop_rgb c=%0d: got %h expected %h", c, rgb, exp);
            end
            vectors++;
            if (underflow_sticky !== (c >= 12)) begin
                miscompares++;
                $display("FAIL sop_sticky c=%0d: got %b expected %b", c, underflow_sticky, (c >= 12));
            end
            st_valid = 1'b1;
            st_sop = (idx == 0);
            st_data = 12'(idx);
            #1;
            if (c == 11) begin
                vectors++;
                if (st_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL sop_refused: got ready %b expected 0", st_ready);
                end
            end
            if (st_valid && st_ready) begin
                if (c > 11 && taken < 0) taken = c;
                idx = (idx + 1) % 32;
                if (idx == 5 && !restarted) begin
                    idx = 0;
                    restarted = 1'b1;
                end
            end
            @(negedge clk_clk);
        end
        st_valid = 1'b0;
        vectors++;
        if (taken !== 197) begin
            miscompares++;
            $display("FAIL sop_taken: got cycle %0d expected 197", taken);
        end
    endtask

    task automatic test_reset_midline();
        int idx = 0;
        do_reset();
        for (int c = 0; c < 37; c++) begin
            st_valid = 1'b1;
            st_sop = (idx == 0);
            st_data = 12'(idx);
            #1;
            if (st_valid && st_ready) idx = (idx + 1) % 32;
            @(negedge clk_clk);
        end
        vectors++;
        if (rgb !== 12'h00B) begin
            miscompares++;
            $display("FAIL midline_pre: got %h expected 00b", rgb);
        end
        reset_reset = 1'b1;
        #1;
        vectors++;
        if (st_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midline_ready: got %b expected 0", st_ready);
        end
        @(negedge clk_clk);
        #1;
        vectors++;
        if ({rgb, vga_vga_blank_n, vga_vga_hsync, vga_vga_vsync, vga_vga_clk, frame_start, underflow_sticky, st_ready}
            !== {12'h000, 7'b0110000}) begin
            miscompares++;
            $display("FAIL midline_reset: got %h/%b%b%b%b%b%b%b expected 000/0110000", rgb, vga_vga_blank_n,
                     vga_vga_hsync, vga_vga_vsync, vga_vga_clk, frame_start, underflow_sticky, st_ready);
        end
        reset_reset = 1'b0;
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            vectors++;
            if ({rgb, frame_start, vga_vga_hsync} !== {e_idx(c), e_fs(c), e_hs(c)}) begin
                miscompares++;
                $display("FAIL midline_restart c=%0d: got %h/%b%b expected %h/%b%b", c, rgb, frame_start,
                         vga_vga_hsync, e_idx(c), e_fs(c), e_hs(c));
            end
            st_valid = 1'b1;
            st_sop = (idx == 0);
            st_data = 12'(idx);
            #1;
            if (st_valid && st_ready) idx = (idx + 1) % 32;
            @(negedge clk_clk);
        end
        st_valid = 1'b0;
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        logic [11:0] pat [8] = '{12'h000, 12'h00F, 12'h0F0, 12'h0FF, 12'hF00, 12'hF0F, 12'hFF0, 12'hFFF};
        logic [11:0] exp;
        do_reset();
        pattern_sel = 1'b1;
        for (int c = 0; c < 30; c++) begin
            exp = (c >= 2 && c < 18) ? pat[(c - 2) / 2] : 12'h000;
            vectors++;
            if ({rgb, underflow_sticky} !== {exp, 1'b0}) begin
                miscompares++;
                $display("FAIL pattern_rgb c=%0d: got %h/%b expected %h/0", c, rgb, underflow_sticky, exp);
            end
            st_valid = 1'b1;
            st_sop = 1'b1;
            st_data = 12'h123;
            #1;
            vectors++;
            if (st_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL pattern_ready c=%0d: got %b expected 1", c, st_ready);
            end
            @(negedge clk_clk);
        end
        pattern_sel = 1'b0;
        st_valid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_stream();
        test_underflow();
        test_misplaced_sop();
        test_reset_midline();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
